// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared memory-map constants for the stack-based multicycle
//                CPU (address width, stack regions, program base).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned MAIN_BASE  = 32'h0000_2800;
    localparam int unsigned MAIN_DEPTH = 256;
    localparam int unsigned RET_BASE   = 32'h0000_2700;
    localparam int unsigned RET_DEPTH  = 256;
    localparam int unsigned PROG_BASE  = 32'h0000_2800;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned depth_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ptr_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ptr_unit_if
//  Description : Strobes from the control FSM into the stack pointer unit and
//                the registered pointers, depths and fault flags it returns.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stack_ptr_unit_if #(
    parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned MS_DEPTH_W = cpu_pkg::depth_w(cpu_pkg::MAIN_DEPTH),
    parameter int unsigned RS_DEPTH_W = cpu_pkg::depth_w(cpu_pkg::RET_DEPTH)
);

    logic                  ms_reg_reset;
    logic                  ms_write;
    logic                  ms_pop;
    logic                  rs_reg_reset;
    logic                  rs_write;
    logic                  rs_pop;

    logic [ADDR_W-1:0]     msp;
    logic [ADDR_W-1:0]     msp_second;
    logic [ADDR_W-1:0]     rsp;
    logic [MS_DEPTH_W-1:0] ms_depth;
    logic [RS_DEPTH_W-1:0] rs_depth;
    logic                  ms_overflow;
    logic                  ms_underflow;
    logic                  rs_overflow;
    logic                  rs_underflow;
    logic                  fault;

    // Control FSM side.
    modport master (
        output ms_reg_reset, ms_write, ms_pop, rs_reg_reset, rs_write, rs_pop,
        input  msp, msp_second, rsp, ms_depth, rs_depth,
               ms_overflow, ms_underflow, rs_overflow, rs_underflow, fault
    );

    // Stack pointer unit side.
    modport slave (
        input  ms_reg_reset, ms_write, ms_pop, rs_reg_reset, rs_write, rs_pop,
        output msp, msp_second, rsp, ms_depth, rs_depth,
               ms_overflow, ms_underflow, rs_overflow, rs_underflow, fault
    );

endinterface
`default_nettype wire

// File: rtl/stack_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ptr
//  Description : One downward-growing stack pointer with occupancy counter
//                and sticky overflow/underflow flags. Faulting operations are
//                suppressed so the pointer never leaves [BASE-DEPTH, BASE].
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ptr #(
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned BASE    = cpu_pkg::MAIN_BASE,
    parameter int unsigned DEPTH   = cpu_pkg::MAIN_DEPTH,
    parameter int unsigned DEPTH_W = cpu_pkg::depth_w(DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               reg_reset_i,
    input  wire logic               write_i,
    input  wire logic               pop_i,
    output logic [ADDR_W-1:0]       sp_o,
    output logic [DEPTH_W-1:0]      depth_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam logic [ADDR_W-1:0]  BASE_V  = ADDR_W'(BASE);
    localparam logic [DEPTH_W-1:0] DEPTH_V = DEPTH_W'(DEPTH);

    logic [ADDR_W-1:0]  sp_q,    sp_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q,   ovf_d;
    logic               udf_q,   udf_d;

    // Next state: reg_reset beats write; pop is only meaningful with write.
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (reg_reset_i) begin
            sp_d    = BASE_V;
            depth_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (write_i) begin
            if (pop_i) begin
                if (depth_q != '0) begin
                    sp_d    = sp_q + ADDR_W'(1);
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    udf_d   = 1'b1;
                end
            end else begin
                if (depth_q < DEPTH_V) begin
                    sp_d    = sp_q - ADDR_W'(1);
                    depth_d = depth_q + DEPTH_W'(1);
                end else begin
                    ovf_d   = 1'b1;
                end
            end
        end
    end

    // State registers; rst discards any concurrent strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= BASE_V;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign sp_o        = sp_q;
    assign depth_o     = depth_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule
`default_nettype wire

// File: rtl/stack_ptr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ptr_unit
//  Description : Main (MSP) and return (RSP) stack pointers for the multicycle
//                CPU, with second-element address and aggregated fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ptr_unit #(
    parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned MAIN_BASE  = cpu_pkg::MAIN_BASE,
    parameter int unsigned MAIN_DEPTH = cpu_pkg::MAIN_DEPTH,
    parameter int unsigned RET_BASE   = cpu_pkg::RET_BASE,
    parameter int unsigned RET_DEPTH  = cpu_pkg::RET_DEPTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    stack_ptr_unit_if.slave  bus
);

    localparam int unsigned MS_DEPTH_W = cpu_pkg::depth_w(MAIN_DEPTH);
    localparam int unsigned RS_DEPTH_W = cpu_pkg::depth_w(RET_DEPTH);

    // The return region sits entirely below the main region, and the return
    // region itself must not run below address zero.
    generate
        if (RET_BASE + MAIN_DEPTH > MAIN_BASE) begin : g_chk_overlap
            $fatal(1, "stack_ptr_unit: return stack region overlaps main stack region");
        end
        if (RET_DEPTH > RET_BASE) begin : g_chk_ret_floor
            $fatal(1, "stack_ptr_unit: RET_DEPTH exceeds RET_BASE");
        end
    endgenerate

    stack_ptr #(
        .ADDR_W  (ADDR_W),
        .BASE    (MAIN_BASE),
        .DEPTH   (MAIN_DEPTH),
        .DEPTH_W (MS_DEPTH_W)
    ) u_main (
        .clk         (clk),
        .rst         (rst),
        .reg_reset_i (bus.ms_reg_reset),
        .write_i     (bus.ms_write),
        .pop_i       (bus.ms_pop),
        .sp_o        (bus.msp),
        .depth_o     (bus.ms_depth),
        .overflow_o  (bus.ms_overflow),
        .underflow_o (bus.ms_underflow)
    );

    stack_ptr #(
        .ADDR_W  (ADDR_W),
        .BASE    (RET_BASE),
        .DEPTH   (RET_DEPTH),
        .DEPTH_W (RS_DEPTH_W)
    ) u_ret (
        .clk         (clk),
        .rst         (rst),
        .reg_reset_i (bus.rs_reg_reset),
        .write_i     (bus.rs_write),
        .pop_i       (bus.rs_pop),
        .sp_o        (bus.rsp),
        .depth_o     (bus.rs_depth),
        .overflow_o  (bus.rs_overflow),
        .underflow_o (bus.rs_underflow)
    );

    // Second-element address wraps naturally at the address width.
    assign bus.msp_second = bus.msp + ADDR_W'(1);
    assign bus.fault      = bus.ms_overflow | bus.ms_underflow
                          | bus.rs_overflow | bus.rs_underflow;

endmodule
`default_nettype wire

// File: tb/tb_stack_ptr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_ptr_unit
//  Description : Self-checking bench for stack_ptr_unit. A behavioural model
//                of both stacks queues the expected outputs per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_ptr_unit;

    typedef logic [70:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stack_ptr_unit_if u_if ();

    stack_ptr_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];
    vec_t exp_v;

    // Behavioural model state.
    int m_msp = 32'h2800, m_msd = 0, m_rsp = 32'h2700, m_rsd = 0;
    bit m_mo = 0, m_mu = 0, m_ro = 0, m_ru = 0;
    int msp_before;

    function automatic vec_t model_vec();
        logic [15:0] a, b, c;
        logic [8:0]  d, e;
        a = 16'(m_msp);
        b = 16'(m_msp + 1);
        c = 16'(m_rsp);
        d = 9'(m_msd);
        e = 9'(m_rsd);
        return {a, b, c, d, e, m_mo, m_mu, m_ro, m_ru, (m_mo | m_mu | m_ro | m_ru)};
    endfunction

    function automatic vec_t obs_vec();
        return {u_if.msp, u_if.msp_second, u_if.rsp, u_if.ms_depth, u_if.rs_depth,
                u_if.ms_overflow, u_if.ms_underflow, u_if.rs_overflow,
                u_if.rs_underflow, u_if.fault};
    endfunction

    // Drive one cycle of strobes, advance the model, queue the expectation.
    task automatic cycle(input bit r, input bit mrr, input bit mw, input bit mp,
                         input bit rrr, input bit rw, input bit rp);
        rst             = r;
        u_if.ms_reg_reset = mrr;
        u_if.ms_write   = mw;
        u_if.ms_pop     = mp;
        u_if.rs_reg_reset = rrr;
        u_if.rs_write   = rw;
        u_if.rs_pop     = rp;
        if (r) begin
            m_msp = 32'h2800; m_msd = 0; m_mo = 0; m_mu = 0;
            m_rsp = 32'h2700; m_rsd = 0; m_ro = 0; m_ru = 0;
        end else begin
            if (mrr) begin
                m_msp = 32'h2800; m_msd = 0; m_mo = 0; m_mu = 0;
            end else if (mw) begin
                if (mp) begin
                    if (m_msd > 0) begin m_msp++; m_msd--; end else m_mu = 1;
                end else begin
                    if (m_msd < 256) begin m_msp--; m_msd++; end else m_mo = 1;
                end
            end
            if (rrr) begin
                m_rsp = 32'h2700; m_rsd = 0; m_ro = 0; m_ru = 0;
            end else if (rw) begin
                if (rp) begin
                    if (m_rsd > 0) begin m_rsp++; m_rsd--; end else m_ru = 1;
                end else begin
                    if (m_rsd < 256) begin m_rsp--; m_rsd++; end else m_ro = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        sb.push_back(model_vec());
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL reset_sb: got %h expected %h", obs_vec(), exp_v);
        end
        checks++;
        if ({u_if.msp, u_if.msp_second, u_if.rsp, u_if.ms_depth, u_if.rs_depth, u_if.fault}
            !== {16'h2800, 16'h2801, 16'h2700, 9'd0, 9'd0, 1'b0}) begin
            errors++; $display("FAIL reset_values: msp=%h second=%h rsp=%h fault=%b required 2800 2801 2700 0",
                               u_if.msp, u_if.msp_second, u_if.rsp, u_if.fault);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs_vec() !== exp_v) begin
                errors++; $display("FAIL push_%0d: got %h expected %h", i, obs_vec(), exp_v);
            end
        end
        checks++;
        if ({u_if.msp, u_if.ms_depth, u_if.rsp} !== {16'h27FD, 9'd3, 16'h2700}) begin
            errors++; $display("FAIL after_pushes: msp=%h depth=%0d rsp=%h required 27fd 3 2700",
                               u_if.msp, u_if.ms_depth, u_if.rsp);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 1, 1, 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs_vec() !== exp_v) begin
                errors++; $display("FAIL pop_%0d: got %h expected %h", i, obs_vec(), exp_v);
            end
        end
        checks++;
        if ({u_if.msp, u_if.ms_depth, u_if.rsp} !== {16'h27FF, 9'd1, 16'h2700}) begin
            errors++; $display("FAIL after_pops: msp=%h depth=%0d rsp=%h required 27ff 1 2700",
                               u_if.msp, u_if.ms_depth, u_if.rsp);
        end
        // pop without write must not move anything
        cycle(0, 0, 0, 1, 0, 0, 1);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL pop_no_write: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    task automatic test_underflow();
        cycle(0, 0, 0, 0, 0, 1, 1);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL underflow_sb: got %h expected %h", obs_vec(), exp_v);
        end
        checks++;
        if ({u_if.rsp, u_if.rs_underflow, u_if.fault} !== {16'h2700, 1'b1, 1'b1}) begin
            errors++; $display("FAIL underflow_flag: rsp=%h udf=%b fault=%b required 2700 1 1",
                               u_if.rsp, u_if.rs_underflow, u_if.fault);
        end
        cycle(0, 0, 0, 0, 0, 1, 0);
        exp_v = sb.pop_front(); checks++;
        if ({u_if.rsp, u_if.rs_underflow} !== {16'h26FF, 1'b1} || obs_vec() !== exp_v) begin
            errors++; $display("FAIL push_after_underflow: got %h expected %h", obs_vec(), exp_v);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL underflow_sticky: got %h expected %h", obs_vec(), exp_v);
        end
        cycle(0, 0, 0, 0, 1, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if ({u_if.rsp, u_if.rs_underflow, u_if.fault} !== {16'h2700, 1'b0, 1'b0} || obs_vec() !== exp_v) begin
            errors++; $display("FAIL rs_reg_reset: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    task automatic test_overflow();
        cycle(0, 1, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL ovf_prep: got %h expected %h", obs_vec(), exp_v);
        end
        for (int i = 0; i < 256; i++) begin
            cycle(0, 0, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs_vec() !== exp_v) begin
                errors++; $display("FAIL fill_%0d: got %h expected %h", i, obs_vec(), exp_v);
            end
        end
        checks++;
        if ({u_if.msp, u_if.ms_depth, u_if.ms_overflow} !== {16'h2700, 9'd256, 1'b0}) begin
            errors++; $display("FAIL full: msp=%h depth=%0d ovf=%b required 2700 256 0",
                               u_if.msp, u_if.ms_depth, u_if.ms_overflow);
        end
        cycle(0, 0, 1, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if ({u_if.msp, u_if.ms_depth, u_if.ms_overflow, u_if.fault} !== {16'h2700, 9'd256, 1'b1, 1'b1}
            || obs_vec() !== exp_v) begin
            errors++; $display("FAIL overflow: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    task automatic test_priority();
        // drain to depth 5 with the overflow flag still set
        while (m_msd > 5) begin
            cycle(0, 0, 1, 1, 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs_vec() !== exp_v) begin
                errors++; $display("FAIL drain_depth_%0d: got %h expected %h", m_msd, obs_vec(), exp_v);
            end
        end
        cycle(0, 1, 1, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if ({u_if.msp, u_if.ms_depth, u_if.ms_overflow, u_if.ms_underflow} !== {16'h2800, 9'd0, 1'b0, 1'b0}
            || obs_vec() !== exp_v) begin
            errors++; $display("FAIL reg_reset_priority: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    task automatic test_concurrency();
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 1, 0, 0, 1, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs_vec() !== exp_v) begin
                errors++; $display("FAIL conc_prep_%0d: got %h expected %h", i, obs_vec(), exp_v);
            end
        end
        msp_before = int'(u_if.msp);
        cycle(0, 0, 1, 0, 0, 1, 1);
        exp_v = sb.pop_front(); checks++;
        if (int'(u_if.msp) !== msp_before - 1 || u_if.rsp !== 16'h26FF || u_if.rs_depth !== 9'd1
            || u_if.fault !== 1'b0 || obs_vec() !== exp_v) begin
            errors++; $display("FAIL concurrency: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    task automatic test_rst_during_write();
        cycle(1, 0, 1, 0, 0, 1, 1);
        exp_v = sb.pop_front(); checks++;
        if ({u_if.msp, u_if.rsp, u_if.ms_depth, u_if.rs_depth} !== {16'h2800, 16'h2700, 9'd0, 9'd0}
            || obs_vec() !== exp_v) begin
            errors++; $display("FAIL rst_wins: got %h expected %h", obs_vec(), exp_v);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs_vec() !== exp_v) begin
            errors++; $display("FAIL post_rst_idle: got %h expected %h", obs_vec(), exp_v);
        end
    endtask

    initial begin
        u_if.ms_reg_reset = 1'b0; u_if.ms_write = 1'b0; u_if.ms_pop = 1'b0;
        u_if.rs_reg_reset = 1'b0; u_if.rs_write = 1'b0; u_if.rs_pop = 1'b0;
        #1;
        test_reset();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_priority();
        test_concurrency();
        test_rst_during_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
